// File: rtl/pifo_sched_ctrl.sv
// Flow scheduler front end for one pifo_base: round-robin admission of flow
// activations, registered grant handshake, decayed reinsert, and flush sequencing.
module pifo_sched_ctrl #(
    parameter  int NUM_ELEMENTS = 16,
    parameter  int MAX_PRIORITY = 256,
    parameter  int DATA_WIDTH   = 8,
    parameter  int NUM_REQ      = 4,
    parameter  int DECAY        = 16,
    localparam int PRIO_WIDTH   = $clog2(MAX_PRIORITY),
    localparam int OCC_WIDTH    = $clog2(NUM_ELEMENTS + 1),
    localparam int PTR_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          i__enable,
    input  logic                          i__flush,
    input  logic [NUM_REQ-1:0]            i__req_valid,
    input  logic [NUM_REQ*PRIO_WIDTH-1:0] i__req_priority,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i__req_data,
    output logic [NUM_REQ-1:0]            o__req_ready,
    output logic                          o__grant_valid,
    output logic [DATA_WIDTH-1:0]         o__grant_flow,
    output logic [PRIO_WIDTH-1:0]         o__grant_priority,
    input  logic                          i__grant_ready,
    output logic                          o__pifo_push_valid,
    output logic [PRIO_WIDTH-1:0]         o__pifo_push_priority,
    output logic [DATA_WIDTH-1:0]         o__pifo_push_data,
    input  logic                          i__pifo_enqueue_ready,
    output logic [PRIO_WIDTH-1:0]         o__pifo_reinsert_priority,
    input  logic                          i__pifo_pop_valid,
    input  logic [PRIO_WIDTH-1:0]         i__pifo_pop_priority,
    input  logic [DATA_WIDTH-1:0]         i__pifo_pop_data,
    output logic                          o__pifo_pop,
    output logic                          o__pifo_clear_all,
    output logic [OCC_WIDTH-1:0]          o__occupancy,
    output logic [1:0]                    o__state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [1:0]             r_settle_cnt;
    logic [1:0]             w_settle_cnt_next;
    logic [PTR_WIDTH-1:0]   r_rr_ptr;
    logic [OCC_WIDTH-1:0]   r_occupancy;
    logic                   r_grant_valid;
    logic [DATA_WIDTH-1:0]  r_grant_flow;
    logic [PRIO_WIDTH-1:0]  r_grant_priority;

    logic                   w_run;
    logic                   w_found;
    logic [PTR_WIDTH-1:0]   w_winner;
    logic [PTR_WIDTH-1:0]   w_idx;
    logic [PRIO_WIDTH-1:0]  w_sel_prio;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic                   w_push_ok;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_reinsert_ok;
    logic                   w_retire;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 2'd0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_cnt_next;
        end
    end

    // SETTLE is held for two cycles so the PIFO's registered flags catch up after a clear.
    always_comb begin
        w_state_next      = r_state;
        w_settle_cnt_next = r_settle_cnt;
        if (i__flush) begin
            w_state_next      = ST_FLUSH;
            w_settle_cnt_next = 2'd0;
        end else begin
            case (r_state)
                ST_IDLE:   if (i__enable) w_state_next = ST_RUN;
                ST_RUN:    if (!i__enable) w_state_next = ST_IDLE;
                ST_FLUSH: begin
                    w_state_next      = ST_SETTLE;
                    w_settle_cnt_next = 2'd1;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == 2'd0)
                        w_state_next = i__enable ? ST_RUN : ST_IDLE;
                    else
                        w_settle_cnt_next = r_settle_cnt - 2'd1;
                end
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    assign w_run = (r_state == ST_RUN);

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = PTR_WIDTH'((int'(r_rr_ptr) + k) % NUM_REQ);
            if (!w_found && i__req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_sel_prio = '0;
        w_sel_data = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (w_winner == PTR_WIDTH'(r)) begin
                w_sel_prio = i__req_priority[r*PRIO_WIDTH +: PRIO_WIDTH];
                w_sel_data = i__req_data[r*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_push_ok = w_run && i__pifo_enqueue_ready
                       && (r_occupancy < OCC_WIDTH'(NUM_ELEMENTS));
    assign w_push    = w_push_ok && w_found;

    always_comb begin
        o__req_ready = '0;
        if (w_push)
            o__req_ready[w_winner] = 1'b1;
    end

    assign o__pifo_push_valid    = w_push;
    assign o__pifo_push_priority = w_push ? w_sel_prio : '0;
    assign o__pifo_push_data     = w_push ? w_sel_data : '0;

    // A head is taken only when the grant slot is empty or being emptied this cycle.
    assign w_pop         = w_run && i__pifo_pop_valid && (!r_grant_valid || i__grant_ready);
    assign w_reinsert_ok = (i__pifo_pop_priority > PRIO_WIDTH'(DECAY));
    assign w_retire      = w_pop && !w_reinsert_ok;

    assign o__pifo_pop               = w_pop;
    assign o__pifo_reinsert_priority = (w_pop && w_reinsert_ok)
                                       ? (i__pifo_pop_priority - PRIO_WIDTH'(DECAY)) : '0;
    assign o__pifo_clear_all         = (r_state == ST_FLUSH);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rr_ptr <= '0;
        end else if (w_push) begin
            r_rr_ptr <= (w_winner == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : (w_winner + PTR_WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_occupancy <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_occupancy <= '0;
        end else if (w_push && !w_retire) begin
            if (r_occupancy < OCC_WIDTH'(NUM_ELEMENTS))
                r_occupancy <= r_occupancy + OCC_WIDTH'(1);
        end else if (!w_push && w_retire) begin
            if (r_occupancy != '0)
                r_occupancy <= r_occupancy - OCC_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_grant_valid    <= 1'b0;
            r_grant_flow     <= '0;
            r_grant_priority <= '0;
        end else if (r_state == ST_FLUSH) begin
            r_grant_valid <= 1'b0;
        end else if (w_pop) begin
            r_grant_valid    <= 1'b1;
            r_grant_flow     <= i__pifo_pop_data;
            r_grant_priority <= i__pifo_pop_priority;
        end else if (w_run && r_grant_valid && i__grant_ready) begin
            r_grant_valid <= 1'b0;
        end
    end

    // The grant is only offered while scheduling; in IDLE it is held but not presented.
    assign o__grant_valid    = r_grant_valid && w_run;
    assign o__grant_flow     = r_grant_flow;
    assign o__grant_priority = r_grant_priority;
    assign o__occupancy      = r_occupancy;
    assign o__state          = r_state;

endmodule

// File: tb/tb_pifo_sched_ctrl.sv
// Directed bench for pifo_sched_ctrl: the PIFO side is driven by hand-chosen
// head values and every expectation is a hand-computed constant.
module tb_pifo_sched_ctrl;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        flush;
    logic [3:0]  reqValid;
    logic [31:0] reqPrio;
    logic [31:0] reqData;
    logic [3:0]  reqReady;
    logic        grantValid;
    logic [7:0]  grantFlow;
    logic [7:0]  grantPrio;
    logic        grantReady;
    logic        pushValid;
    logic [7:0]  pushPrio;
    logic [7:0]  pushData;
    logic        enqReady;
    logic [7:0]  reinsertPrio;
    logic        popValid;
    logic [7:0]  popPrio;
    logic [7:0]  popData;
    logic        pifoPop;
    logic        clearAll;
    logic [4:0]  occupancy;
    logic [1:0]  state;

    int checkCount = 0;
    int passCount  = 0;

    int chainPrio [6] = '{84, 68, 52, 36, 20, 4};
    int chainReins[6] = '{68, 52, 36, 20, 4, 0};
    int rrOrder   [5] = '{0, 1, 2, 3, 0};

    pifo_sched_ctrl dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .i__enable                 (enable),
        .i__flush                  (flush),
        .i__req_valid              (reqValid),
        .i__req_priority           (reqPrio),
        .i__req_data               (reqData),
        .o__req_ready              (reqReady),
        .o__grant_valid            (grantValid),
        .o__grant_flow             (grantFlow),
        .o__grant_priority         (grantPrio),
        .i__grant_ready            (grantReady),
        .o__pifo_push_valid        (pushValid),
        .o__pifo_push_priority     (pushPrio),
        .o__pifo_push_data         (pushData),
        .i__pifo_enqueue_ready     (enqReady),
        .o__pifo_reinsert_priority (reinsertPrio),
        .i__pifo_pop_valid         (popValid),
        .i__pifo_pop_priority      (popPrio),
        .i__pifo_pop_data          (popData),
        .o__pifo_pop               (pifoPop),
        .o__pifo_clear_all         (clearAll),
        .o__occupancy              (occupancy),
        .o__state                  (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] prio,
                                 input logic [31:0] data, input logic enq,
                                 input logic hValid, input logic [7:0] hPrio,
                                 input logic [7:0] hData, input logic gReady);
        reqValid   = valid;
        reqPrio    = prio;
        reqData    = data;
        enqReady   = enq;
        popValid   = hValid;
        popPrio    = hPrio;
        popData    = hData;
        grantReady = gReady;
        #1;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_state"}, 32'(state), 0);
        checkOutput({tag, "_occ"}, 32'(occupancy), 0);
        checkOutput({tag, "_gvalid"}, 32'(grantValid), 0);
        checkOutput({tag, "_gflow"}, 32'(grantFlow), 0);
        checkOutput({tag, "_gprio"}, 32'(grantPrio), 0);
        checkOutput({tag, "_ready"}, 32'(reqReady), 0);
        checkOutput({tag, "_push"}, 32'(pushValid), 0);
        checkOutput({tag, "_pop"}, 32'(pifoPop), 0);
        checkOutput({tag, "_reins"}, 32'(reinsertPrio), 0);
        checkOutput({tag, "_clear"}, 32'(clearAll), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        flush   = 1'b0;
        applyStimulus(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        nextCycle();
        nextCycle();
        reset_n = 1'b1;
        #1;
        checkResetValues("rst");

        // Single flow through its whole decay chain.
        enable = 1'b1;
        nextCycle();
        checkOutput("en_state", 32'(state), 1);
        applyStimulus(4'b0100, {8'd0, 8'd100, 8'd0, 8'd0}, {8'h00, 8'h2A, 8'h00, 8'h00},
                      1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("a_ready", 32'(reqReady), 'b0100);
        checkOutput("a_push", 32'(pushValid), 1);
        checkOutput("a_pprio", 32'(pushPrio), 100);
        checkOutput("a_pdata", 32'(pushData), 'h2A);
        nextCycle();
        checkOutput("a_occ1", 32'(occupancy), 1);
        applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1, 8'd100, 8'h2A, 1'b1);
        checkOutput("a_pop", 32'(pifoPop), 1);
        checkOutput("a_reins100", 32'(reinsertPrio), 84);
        checkOutput("a_gv_early", 32'(grantValid), 0);
        nextCycle();
        checkOutput("a_gvalid", 32'(grantValid), 1);
        checkOutput("a_gflow", 32'(grantFlow), 'h2A);
        checkOutput("a_gprio", 32'(grantPrio), 100);
        checkOutput("a_occ_hold", 32'(occupancy), 1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1, 8'(chainPrio[i]), 8'h2A, 1'b1);
            checkOutput("chain_pop", 32'(pifoPop), 1);
            checkOutput("chain_reins", 32'(reinsertPrio), 32'(chainReins[i]));
            nextCycle();
            checkOutput("chain_gprio", 32'(grantPrio), 32'(chainPrio[i]));
        end
        checkOutput("a_occ_retired", 32'(occupancy), 0);
        applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b1);
        nextCycle();
        checkOutput("a_drained", 32'(grantValid), 0);

        // Decay boundary: strictly greater than DECAY reinserts.
        applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1, 8'd17, 8'h01, 1'b0);
        checkOutput("b_reins17", 32'(reinsertPrio), 1);
        applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1, 8'd16, 8'h01, 1'b0);
        checkOutput("b_reins16", 32'(reinsertPrio), 0);
        applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 8'd16, 8'h01, 1'b0);
        checkOutput("b_reins_nopop", 32'(reinsertPrio), 0);

        // Round robin: one push from requester 3 brings the pointer back to 0.
        applyStimulus(4'b1000, {8'd30, 8'd0, 8'd0, 8'd0}, {8'h03, 8'h00, 8'h00, 8'h00},
                      1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        checkOutput("rr_wrap_ready", 32'(reqReady), 'b1000);
        nextCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'hA3, 8'hA2, 8'hA1, 8'hA0},
                          1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
            checkOutput("rr_ready", 32'(reqReady), 32'(1) << rrOrder[i]);
            checkOutput("rr_pdata", 32'(pushData), 32'('hA0 + rrOrder[i]));
            nextCycle();
        end
        checkOutput("rr_occ", 32'(occupancy), 6);

        // Fill to capacity while the downstream stalls on a pending grant.
        applyStimulus(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'hA3, 8'hA2, 8'hA1, 8'hA0},
                      1'b1, 1'b1, 8'd200, 8'h11, 1'b0);
        checkOutput("f_pop", 32'(pifoPop), 1);
        checkOutput("f_reins", 32'(reinsertPrio), 184);
        checkOutput("f_ready", 32'(reqReady), 'b0010);
        nextCycle();
        checkOutput("f_occ7", 32'(occupancy), 7);
        applyStimulus(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'hA3, 8'hA2, 8'hA1, 8'hA0},
                      1'b1, 1'b1, 8'd184, 8'h11, 1'b0);
        checkOutput("f_nopop", 32'(pifoPop), 0);
        for (int i = 0; i < 9; i++)
            nextCycle();
        checkOutput("f_occ16", 32'(occupancy), 16);
        checkOutput("f_ready0", 32'(reqReady), 0);
        checkOutput("f_push0", 32'(pushValid), 0);
        checkOutput("f_gvalid", 32'(grantValid), 1);
        checkOutput("f_gflow", 32'(grantFlow), 'h11);
        checkOutput("f_gprio", 32'(grantPrio), 200);
        nextCycle();
        checkOutput("f_occ_stay", 32'(occupancy), 16);
        checkOutput("f_gstable", 32'(grantPrio), 200);

        // At capacity: reinsert keeps the count, retire frees a slot only next cycle.
        applyStimulus(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'hA3, 8'hA2, 8'hA1, 8'hA0},
                      1'b1, 1'b1, 8'd184, 8'h11, 1'b1);
        checkOutput("full_pop", 32'(pifoPop), 1);
        checkOutput("full_reins", 32'(reinsertPrio), 168);
        checkOutput("full_ready", 32'(reqReady), 0);
        nextCycle();
        checkOutput("full_occ", 32'(occupancy), 16);
        checkOutput("full_gprio", 32'(grantPrio), 184);
        applyStimulus(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'hA3, 8'hA2, 8'hA1, 8'hA0},
                      1'b1, 1'b1, 8'd10, 8'h22, 1'b1);
        checkOutput("ret_reins", 32'(reinsertPrio), 0);
        checkOutput("ret_ready", 32'(reqReady), 0);
        nextCycle();
        checkOutput("ret_occ", 32'(occupancy), 15);
        checkOutput("ret_gflow", 32'(grantFlow), 'h22);

        // Push and pop-with-reinsert in the same cycle.
        applyStimulus(4'b0001, {8'd40, 8'd30, 8'd20, 8'd200}, {8'hA3, 8'hA2, 8'hA1, 8'h55},
                      1'b1, 1'b1, 8'd50, 8'h33, 1'b1);
        checkOutput("mix_ready", 32'(reqReady), 'b0001);
        checkOutput("mix_pprio", 32'(pushPrio), 200);
        checkOutput("mix_pop", 32'(pifoPop), 1);
        checkOutput("mix_reins", 32'(reinsertPrio), 34);
        nextCycle();
        checkOutput("mix_occ", 32'(occupancy), 16);
        checkOutput("mix_gprio", 32'(grantPrio), 50);
        applyStimulus(4'b0000, 32'h0, 32'h0, 1'b1, 1'b1, 8'd200, 8'h55, 1'b1);
        nextCycle();
        checkOutput("mix_next_gprio", 32'(grantPrio), 200);
        checkOutput("mix_next_gflow", 32'(grantFlow), 'h55);

        // Flush with a pending grant and a full PIFO.
        applyStimulus(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'hA3, 8'hA2, 8'hA1, 8'hA0},
                      1'b1, 1'b1, 8'd184, 8'h55, 1'b0);
        flush = 1'b1;
        #1;
        checkOutput("fl_pending_nopop", 32'(pifoPop), 0);
        nextCycle();
        flush = 1'b0;
        #1;
        checkOutput("fl_state", 32'(state), 2);
        checkOutput("fl_clear", 32'(clearAll), 1);
        checkOutput("fl_gvalid", 32'(grantValid), 0);
        checkOutput("fl_push", 32'(pushValid), 0);
        checkOutput("fl_pop", 32'(pifoPop), 0);
        nextCycle();
        checkOutput("st1_state", 32'(state), 3);
        checkOutput("st1_occ", 32'(occupancy), 0);
        checkOutput("st1_clear", 32'(clearAll), 0);
        checkOutput("st1_push", 32'(pushValid), 0);
        checkOutput("st1_pop", 32'(pifoPop), 0);
        nextCycle();
        checkOutput("st2_state", 32'(state), 3);
        checkOutput("st2_push", 32'(pushValid), 0);
        checkOutput("st2_pop", 32'(pifoPop), 0);
        applyStimulus(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'hA3, 8'hA2, 8'hA1, 8'hA0},
                      1'b1, 1'b0, 8'd0, 8'd0, 1'b0);
        nextCycle();
        checkOutput("post_state", 32'(state), 1);
        checkOutput("post_gvalid", 32'(grantValid), 0);
        checkOutput("post_ready", 32'(reqReady), 'b0010);

        // Reset in the middle of live traffic.
        applyStimulus(4'b1111, {8'd40, 8'd30, 8'd20, 8'd10}, {8'hA3, 8'hA2, 8'hA1, 8'hA0},
                      1'b1, 1'b1, 8'd90, 8'h77, 1'b1);
        nextCycle();
        checkOutput("live_gvalid", 32'(grantValid), 1);
        checkOutput("live_gflow", 32'(grantFlow), 'h77);
        reset_n = 1'b0;
        nextCycle();
        checkResetValues("mid");
        reset_n = 1'b1;
        nextCycle();
        checkOutput("rel_state", 32'(state), 1);
        checkOutput("rel_ready", 32'(reqReady), 'b0001);

        applyStimulus(4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
